// File: rtl/led_sched_pkg.sv
// Shared types and helpers for the LED time-slicing scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package led_sched_pkg;

  localparam int LED_W   = 8;
  // Upper bound on requesters, which also sets the one-hot decoder width.
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Converts a one-hot (or all-zero) vector to its bit index. All-zero maps to 0.
  // The OR-reduction form assumes one-hot input, which the arbiter guarantees.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_share_scheduler_tick_gen.sv
// Free-running prescaler producing a one-cycle dwell tick every TICK_DIV clocks.
// Latency: tick is registered, high in the cycle after the counter hits TICK_DIV-1.
// Backpressure: none; runs regardless of arbitration state.
module tick_gen #(
  parameter int TICK_DIV = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("tick_gen: TICK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic             at_wrap;

  assign at_wrap = (cnt == CNT_W'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and register the wrap as a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= at_wrap;
      cnt  <= at_wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_share_scheduler.sv
// Round-robin owner of the 8-bit LED bank with a tick-measured minimum dwell.
// Latency: grant/busy update at the request edge; led follows grant one cycle later.
// Backpressure: requesters hold req high until granted; a grant drops the same edge its req falls.
module led_share_scheduler
  import led_sched_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                TICK_DIV     = 32'd10000000,
  parameter int                DWELL_TICKS  = 4,
  parameter logic [LED_W-1:0]  IDLE_PATTERN = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [LED_W*NUM_REQ-1:0]   req_data,
  output logic [LED_W-1:0]           led,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic                       tick
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW_W  = (DWELL_TICKS >= 1) ? $clog2(DWELL_TICKS + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("led_share_scheduler: NUM_REQ must be within 2..8");
  end

  if (DWELL_TICKS < 1) begin : g_bad_dwell
    $error("led_share_scheduler: DWELL_TICKS must be at least 1");
  end

  state_t               state;
  logic [IDX_W-1:0]     last_idx;
  logic [DW_W-1:0]      dwell;

  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 own_req;
  logic                 others_pending;
  logic                 dwell_done;
  logic [MAX_REQ-1:0]   grant_ext;
  logic [IDX_W-1:0]     grant_idx;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Round-robin search starting just after the last owner. Scanning offsets
  // high-to-low lets the nearest asserted request overwrite farther ones.
  // The current owner sits at offset NUM_REQ, so any other pending request
  // always wins over it when rotating.
  always_comb begin
    cand     = '0;
    pick_vld = 1'b0;
    pick_idx = last_idx;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_oh        = NUM_REQ'(1) << pick_idx;
  assign own_req        = |(req & grant);
  assign others_pending = |(req & ~grant);
  assign dwell_done     = (dwell == DW_W'(DWELL_TICKS));
  assign grant_ext      = MAX_REQ'(grant);
  assign grant_idx      = IDX_W'(onehot_to_idx(grant_ext));

  // Arbitration FSM: IDLE waits for any request; HOLD keeps the owner until it
  // releases or its dwell has expired while someone else is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dwell    <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state    <= HOLD;
            grant    <= pick_oh;
            busy     <= 1'b1;
            dwell    <= '0;
            last_idx <= pick_idx;
          end
        end
        HOLD: begin
          if (!own_req) begin
            // A release always takes priority over tick or dwell expiry.
            if (others_pending) begin
              grant    <= pick_oh;
              last_idx <= pick_idx;
              dwell    <= '0;
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
              dwell <= '0;
            end
          end else if (dwell_done && others_pending) begin
            grant    <= pick_oh;
            last_idx <= pick_idx;
            dwell    <= '0;
          end else if (tick && !dwell_done) begin
            // Saturates at DWELL_TICKS so a lone owner keeps the LEDs indefinitely.
            dwell <= dwell + DW_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // LED mux resampled every cycle so live patterns (e.g. a counter) stay current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= IDLE_PATTERN;
    end else begin
      led <= (state == HOLD) ? req_data[LED_W*grant_idx +: LED_W] : IDLE_PATTERN;
    end
  end

endmodule
